// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the last-grant history lives in the caller.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_CPU;
    // Under contention the port that did not win last time goes next.
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else if (req[PORT_DMA]) begin
      gnt_idx = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between the CPU (port 0) and a DMA engine (port 1);
// each grant holds the memory port for WAIT+1 cycles, then acks for one cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_e        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic gnt_valid;
  logic gnt_idx;

  rr_arb2 u_rr_arb2 (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_idx;
          last_grant_d = gnt_idx;
          we_d         = (gnt_idx == PORT_DMA) ? dma_we    : cpu_we;
          addr_d       = (gnt_idx == PORT_DMA) ? dma_addr  : cpu_addr;
          wdata_d      = (gnt_idx == PORT_DMA) ? dma_wdata : cpu_wdata;
          wcnt_d       = WAIT_CNT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (wcnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == PORT_DMA) dma_rdata_d = mem_rdata;
            else                     cpu_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wcnt_q       <= 4'd0;
      last_grant_q <= PORT_DMA;
      owner_q      <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Memory-side outputs decode only registered state, never the requests.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;

  assign cpu_ack   = (state_q == DONE) && (owner_q == PORT_CPU);
  assign dma_ack   = (state_q == DONE) && (owner_q == PORT_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared instruction/data memory of the multicycle MIPS between two requesters: the CPU (port 0) and a DMA/loader engine (port 1). Each granted access is held stable on the memory port for a fixed number of wait states, then completed with a one-cycle ack. The CPU side exposes a stall signal that the multicycle control FSM uses to freeze its state register and enables while a fetch or load/store is outstanding.

## Interface
- WAIT, default 2: memory wait states; valid range 0..15; each access occupies the memory port for WAIT+1 cycles.
- AW, default 32: address width.
- DW, default 32: data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  byte address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data, valid from the cpu_ack cycle and held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same meaning as the CPU ports, for port 1
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data, valid in the last ACCESS cycle
- owner  out  1  port currently or last granted (0 = CPU, 1 = DMA)

## Operation
- State machine states:
  - IDLE: if any req is high, select a winner, latch its we/addr/wdata, set owner, load wcnt = WAIT, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_en = 1; mem_we = latched we; address and data stable. If wcnt == 0, capture mem_rdata into the owner's rdata register (reads only) and go to DONE. Otherwise decrement wcnt.
  - DONE: pulse the owner's ack for one cycle, go to IDLE. Requests are not sampled in DONE.
- Arbitration:
  - Round-robin on contention: the port not equal to last_grant wins.
  - A lone request wins regardless of last_grant.
  - last_grant updates on every grant.
- Requester rules:
  - Hold req, we, addr and wdata until ack.
  - Deassert req (or present a new request) on the cycle after ack.
- Dropping req before ack does not abort the access; the ack still pulses.
- Writes: rdata registers are unchanged.
- wcnt width is 4 bits.
- Reset values:
  - state = IDLE, last_grant = 1 (CPU wins the first contention), owner = 0.
  - mem_en = mem_we = 0.
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0.
  - Both acks = 0.
- Reset mid-access abandons the access immediately: no ack, mem_we low on the next cycle.

## Timing
- Uncontended: req sampled high in IDLE at cycle 0 → ACCESS in cycles 1..WAIT+1 → ack in cycle WAIT+2 → IDLE in cycle WAIT+3.
- Throughput: one access per WAIT+3 cycles. Back-to-back requests are interleaved CPU/DMA under contention.
- With WAIT = 0: ACCESS lasts 1 cycle and ack arrives 2 cycles after the request.
- Worst-case CPU wait: 2·(WAIT+3) cycles from cpu_req to cpu_ack.
- mem_addr, mem_wdata and mem_we are registered, with no combinational path from req to the memory.
- cpu_stall is the only combinational output.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - port index constants PORT_CPU = 0, PORT_DMA = 1
- Sub-module rr_arb2: two-input round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational; last_grant is stored in mem_arbiter.

## Test plan
- Reset, then CPU read of 0x0000_0040 with mem_rdata = 0x1234_5678, WAIT = 2 → mem_en high cycles 1–3, cpu_ack in cycle 4, cpu_rdata = 0x1234_5678, cpu_stall high cycles 0–3.
- DMA write of 0xDEAD_BEEF to 0x100 → mem_we high for exactly 3 cycles with mem_addr = 0x100, dma_ack pulses once, cpu_rdata unchanged.
- Both req high in the same cycle right after reset → CPU granted first, DMA second; CPU re-requests after its ack → DMA served before the CPU's second access.
- WAIT = 0, CPU and DMA requesting continuously → acks alternate CPU, DMA, CPU with one access every 3 cycles.
- reset asserted in the second ACCESS cycle of a write → no ack, mem_en/mem_we low next cycle, state IDLE, rdata registers 0.
- dma_req dropped mid-access → dma_ack still pulses, then IDLE; a pending cpu_req is granted immediately after.
